// File: rtl/frame_scanout.sv
// Raster timing generator and frame-buffer scanout: one 48-bit word (two pixels) per read, one pixel out per clock.
// Latency RD_LAT+1 from raster position to output; no backpressure, the raster free-runs at the pixel clock.
module frame_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int RD_LAT   = 2,
  parameter int ADDR_W   = 19
) (
  input  logic              i_clk24,
  input  logic              i_rst,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_en,
  input  logic [47:0]       i_rd_data,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_de,
  output logic [7:0]        o_pix_r,
  output logic [7:0]        o_pix_g,
  output logic [7:0]        o_pix_b,
  output logic              o_frame_start,
  output logic              o_busy
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT + 1);
  localparam int VW    = $clog2(V_TOT + 1);
  localparam int L     = RD_LAT + 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic sel;
    logic fs;
  } tag_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [HW-1:0]     r_h;
  logic [VW-1:0]     r_v;
  logic [ADDR_W-1:0] r_word;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_en;
  tag_t              r_pipe [L];
  logic [23:0]       r_hold;

  logic              w_run;
  logic              w_frame_end;
  logic              w_act;
  logic              w_rd;
  tag_t              w_tag;
  tag_t              w_out;
  logic [23:0]       w_pix;

  always_comb begin
    w_run       = (r_state == ST_RUN);
    w_frame_end = w_run && (r_h == H_LAST) && (r_v == V_LAST);
    w_act       = w_run && (r_h < H_ACT) && (r_v < V_ACT);
    w_rd        = w_act && !r_h[0];
    w_tag       = '0;
    w_tag.de    = w_act;
    w_tag.hs    = w_run && (r_h >= HS_BEG) && (r_h < HS_END);
    w_tag.vs    = w_run && (r_v >= VS_BEG) && (r_v < VS_END);
    w_tag.sel   = r_h[0];
    w_tag.fs    = w_run && (r_h == '0) && (r_v == '0);
  end

  // en only matters in IDLE or on the last raster position, so frames are never cut short.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_en) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_frame_end && !i_en) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk24) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk24) begin
    if (i_rst || !w_run || w_frame_end) begin
      r_h    <= '0;
      r_v    <= '0;
      r_word <= '0;
    end else begin
      if (w_rd) r_word <= r_word + ADDR_W'(1);
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= r_v + VW'(1);
      end else begin
        r_h <= r_h + HW'(1);
      end
    end
  end

  always_ff @(posedge i_clk24) begin
    if (i_rst) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_rd_en <= w_rd;
      if (w_rd) r_rd_addr <= r_word;
    end
  end

  always_ff @(posedge i_clk24) begin
    if (i_rst) begin
      for (int i = 0; i < L; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_tag;
      for (int i = 1; i < L; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_out = r_pipe[L-1];

  // Even pixel comes straight off the memory's output register; the odd one reuses the held upper half.
  always_ff @(posedge i_clk24) begin
    if (i_rst)                       r_hold <= '0;
    else if (w_out.de && !w_out.sel) r_hold <= i_rd_data[47:24];
  end

  assign w_pix         = w_out.sel ? r_hold : i_rd_data[23:0];
  assign o_pix_r       = w_out.de ? w_pix[23:16] : 8'h00;
  assign o_pix_b       = w_out.de ? w_pix[15:8]  : 8'h00;
  assign o_pix_g       = w_out.de ? w_pix[7:0]   : 8'h00;
  assign o_de          = w_out.de;
  assign o_hsync       = w_out.hs ? HS_POL : ~HS_POL;
  assign o_vsync       = w_out.vs ? VS_POL : ~VS_POL;
  assign o_frame_start = w_out.fs;
  assign o_busy        = w_run;
  assign o_rd_en       = r_rd_en & ~i_rst;
  assign o_rd_addr     = r_rd_addr;

endmodule

// File: tb/tb_frame_scanout.sv
// Directed bench for frame_scanout: default 640x480 timing (RD_LAT 2 and 4) plus a tiny raster for whole-frame behaviour.
module tb_frame_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, rst_s, en_s;

  logic [18:0] addr_a, addr_b, addr_s;
  logic        rd_en_a, rd_en_b, rd_en_s;
  logic [47:0] rdd_a, rdd_b, rdd_s;
  logic        hs_a, vs_a, de_a, fs_a, busy_a;
  logic        hs_b, vs_b, de_b, fs_b, busy_b;
  logic        hs_s, vs_s, de_s, fs_s, busy_s;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_s, g_s, b_s;

  frame_scanout dut_a (
    .i_clk24(clk), .i_rst(rst), .i_en(en), .o_rd_addr(addr_a), .o_rd_en(rd_en_a),
    .i_rd_data(rdd_a), .o_hsync(hs_a), .o_vsync(vs_a), .o_de(de_a),
    .o_pix_r(r_a), .o_pix_g(g_a), .o_pix_b(b_a), .o_frame_start(fs_a), .o_busy(busy_a));

  frame_scanout #(.RD_LAT(4)) dut_b (
    .i_clk24(clk), .i_rst(rst), .i_en(en), .o_rd_addr(addr_b), .o_rd_en(rd_en_b),
    .i_rd_data(rdd_b), .o_hsync(hs_b), .o_vsync(vs_b), .o_de(de_b),
    .o_pix_r(r_b), .o_pix_g(g_b), .o_pix_b(b_b), .o_frame_start(fs_b), .o_busy(busy_b));

  // 16 clocks per line, 8 lines per frame, 4 words per active line.
  frame_scanout #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                  .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_s (
    .i_clk24(clk), .i_rst(rst_s), .i_en(en_s), .o_rd_addr(addr_s), .o_rd_en(rd_en_s),
    .i_rd_data(rdd_s), .o_hsync(hs_s), .o_vsync(vs_s), .o_de(de_s),
    .o_pix_r(r_s), .o_pix_g(g_s), .o_pix_b(b_s), .o_frame_start(fs_s), .o_busy(busy_s));

  localparam logic [47:0] JUNK = 48'hBAD0_BAD0_BAD0;

  function automatic logic [47:0] mem_word(input logic [18:0] a);
    logic [23:0] k;
    k = {5'd0, a};
    return {24'h00FF00 + k, 24'hFF0000 + k};
  endfunction

  function automatic logic [23:0] exp_pix(input int idx, input int npix);
    int k;
    k = (idx % npix) / 2;
    return (idx % 2 == 0) ? 24'hFF0000 + 24'(k) : 24'h00FF00 + 24'(k);
  endfunction

  // Small-raster reference: is position p (clocks since (0,0)) an active position?
  function automatic bit s_active(input int p);
    int q;
    q = p % 128;
    return ((q % 16) < 8) && ((q / 16) < 4);
  endfunction

  function automatic int s_addr(input int p);
    int q;
    q = p % 128;
    return (q / 16) * 4 + (q % 16) / 2;
  endfunction

  logic [47:0] mq_a [2];
  logic [47:0] mq_b [4];
  logic [47:0] mq_s [2];

  always @(posedge clk) begin
    mq_a[0] <= rd_en_a ? mem_word(addr_a) : JUNK;
    mq_a[1] <= mq_a[0];
    mq_b[0] <= rd_en_b ? mem_word(addr_b) : JUNK;
    for (int i = 1; i < 4; i++) mq_b[i] <= mq_b[i-1];
    mq_s[0] <= rd_en_s ? mem_word(addr_s) : JUNK;
    mq_s[1] <= mq_s[0];
  end

  assign rdd_a = mq_a[1];
  assign rdd_b = mq_b[3];
  assign rdd_s = mq_s[1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int first_rd_a = -1, rd_l0 = 0, rd_pat_err = 0, addr_err = 0, exp_addr = 0, last_addr_l0 = -1;
  int first_l1 = -1, addr_l1 = -1;
  int first_de_a = -1, de_l0_a = 0, pix_err_a = 0, pidx_a = 0, fs_cnt_a = 0, fs_c_a = -1;
  int hs_fall1 = -1, hs_fall2 = -1, hs_low_l0 = 0, vs_low_a = 0;
  int first_de_b = -1, de_l0_b = 0, pix_err_b = 0, pidx_b = 0, fs_c_b = -1;
  int rd_err_s = 0, de_err_s = 0, pix_err_s = 0, pidx_s = 0, fs_cnt_s = 0;
  int hs_low_s = 0, vs_low_s = 0, hs_fall_s1 = -1, hs_fall_s2 = -1, vs_fall_s = -1;
  logic prev_hs_a = 1'b1, prev_hs_s = 1'b1, prev_vs_s = 1'b1;
  logic [23:0] first4 [4];
  bit exp_rd, exp_de;

  initial begin
    rst = 1'b1; en = 1'b1; rst_s = 1'b1; en_s = 1'b0;
    repeat (3) tick();

    chk("rst_hsync", hs_a, 1);
    chk("rst_vsync", vs_a, 1);
    chk("rst_de", de_a, 0);
    chk("rst_pix", {r_a, g_a, b_a}, 0);
    chk("rst_rd_en", rd_en_a, 0);
    chk("rst_rd_addr", addr_a, 0);
    chk("rst_frame_start", fs_a, 0);
    chk("rst_busy", busy_a, 0);

    rst = 1'b0;
    tick();
    chk("run_busy", busy_a, 1);
    chk("run_de_early", de_a, 0);

    for (int c = 1; c <= 1620; c++) begin
      tick();
      if (c < 800 && rd_en_a !== ((c % 2 == 1) && c <= 639)) rd_pat_err++;
      if (rd_en_a) begin
        if (first_rd_a < 0) first_rd_a = c;
        if (c < 800) begin
          rd_l0++;
          if (addr_a !== 19'(exp_addr)) addr_err++;
          exp_addr++;
          last_addr_l0 = int'(addr_a);
        end else if (first_l1 < 0) begin
          first_l1 = c;
          addr_l1  = int'(addr_a);
        end
      end
      if (de_a) begin
        if (first_de_a < 0) first_de_a = c;
        if (c < 800) de_l0_a++;
        if (pidx_a < 4) first4[pidx_a] = {r_a, b_a, g_a};
        if ({r_a, b_a, g_a} !== exp_pix(pidx_a, 307200)) pix_err_a++;
        pidx_a++;
      end
      if (fs_a) begin fs_cnt_a++; fs_c_a = c; end
      if (!hs_a && prev_hs_a) begin
        if (hs_fall1 < 0) hs_fall1 = c; else if (hs_fall2 < 0) hs_fall2 = c;
      end
      if (!hs_a && c < 800) hs_low_l0++;
      prev_hs_a = hs_a;
      if (!vs_a) vs_low_a++;
      if (de_b) begin
        if (first_de_b < 0) first_de_b = c;
        if (c < 800) de_l0_b++;
        if ({r_b, b_b, g_b} !== exp_pix(pidx_b, 307200)) pix_err_b++;
        pidx_b++;
      end
      if (fs_b && fs_c_b < 0) fs_c_b = c;
    end

    chk("first_rd_en", first_rd_a, 1);
    chk("rd_every_2", rd_pat_err, 0);
    chk("rd_count_line0", rd_l0, 320);
    chk("rd_addr_seq", addr_err, 0);
    chk("rd_last_addr_line0", last_addr_l0, 319);
    chk("line1_first_rd", first_l1, 801);
    chk("line1_addr", addr_l1, 320);
    chk("first_de", first_de_a, 3);
    chk("de_len_line0", de_l0_a, 640);
    chk("pix0", first4[0], 24'hFF0000);
    chk("pix1", first4[1], 24'h00FF00);
    chk("pix2", first4[2], 24'hFF0001);
    chk("pix3", first4[3], 24'h00FF01);
    chk("pix_stream", pix_err_a, 0);
    chk("fs_count", fs_cnt_a, 1);
    chk("fs_with_de", fs_c_a, 3);
    chk("hsync_start", hs_fall1, 659);
    chk("hsync_width", hs_low_l0, 96);
    chk("line_period", hs_fall2 - hs_fall1, 800);
    chk("vsync_idle_top", vs_low_a, 0);
    chk("lat4_first_de", first_de_b, 5);
    chk("lat4_fs", fs_c_b, 5);
    chk("lat4_de_len", de_l0_b, 640);
    chk("lat4_pix", pix_err_b, 0);

    // Tiny raster: two frames, en dropped partway through the second.
    rst = 1'b1;
    rst_s = 1'b0; en_s = 1'b1;
    tick();
    for (int c = 1; c <= 280; c++) begin
      tick();
      exp_rd = (c - 1 < 256) && s_active(c - 1) && ((c - 1) % 2 == 0);
      if (rd_en_s !== exp_rd || (exp_rd && addr_s !== 19'(s_addr(c - 1)))) rd_err_s++;
      exp_de = (c >= 3) && (c - 3 < 256) && s_active(c - 3);
      if (de_s !== exp_de) de_err_s++;
      if (de_s) begin
        if ({r_s, b_s, g_s} !== exp_pix(pidx_s, 32)) pix_err_s++;
        pidx_s++;
      end
      if (fs_s) fs_cnt_s++;
      if (c >= 3 && c < 131) begin
        if (!hs_s) hs_low_s++;
        if (!vs_s) vs_low_s++;
      end
      if (!hs_s && prev_hs_s) begin
        if (hs_fall_s1 < 0) hs_fall_s1 = c; else if (hs_fall_s2 < 0) hs_fall_s2 = c;
      end
      if (!vs_s && prev_vs_s && vs_fall_s < 0) vs_fall_s = c;
      prev_hs_s = hs_s;
      prev_vs_s = vs_s;
      if (c == 3)   chk("s_fs_first", fs_s, 1);
      if (c == 131) chk("s_fs_second", fs_s, 1);
      if (c == 17)  chk("s_line1_addr", addr_s, 4);
      if (c == 55)  chk("s_last_addr", addr_s, 15);
      if (c == 129) chk("s_frame2_addr", addr_s, 0);
      if (c == 255) chk("s_busy_last", busy_s, 1);
      if (c == 256) chk("s_busy_idle", busy_s, 0);
      if (c == 259) begin
        chk("s_idle_de", de_s, 0);
        chk("s_idle_hs", hs_s, 1);
        chk("s_idle_vs", vs_s, 1);
        chk("s_idle_pix", {r_s, g_s, b_s}, 0);
      end
      if (c == 160) en_s = 1'b0;
    end
    chk("s_rd_model", rd_err_s, 0);
    chk("s_de_model", de_err_s, 0);
    chk("s_pix", pix_err_s, 0);
    chk("s_fs_count", fs_cnt_s, 2);
    chk("s_hs_low", hs_low_s, 24);
    chk("s_vs_low", vs_low_s, 32);
    chk("s_hs_start", hs_fall_s1, 13);
    chk("s_hs_period", hs_fall_s2 - hs_fall_s1, 16);
    chk("s_vs_start", vs_fall_s, 83);

    // Restart, then reset in the middle of line 2.
    en_s = 1'b1;
    tick();
    chk("s_restart_busy", busy_s, 1);
    tick();
    chk("s_restart_rd", rd_en_s, 1);
    chk("s_restart_addr", addr_s, 0);
    repeat (2) tick();
    chk("s_restart_de", de_s, 1);
    chk("s_restart_fs", fs_s, 1);
    chk("s_restart_pix", {r_s, b_s, g_s}, 24'hFF0000);
    repeat (34) tick();
    chk("s_pre_rst_rd", rd_en_s, 1);
    chk("s_pre_rst_addr", addr_s, 10);
    rst_s = 1'b1;
    #1;
    chk("s_rst_cycle_rd", rd_en_s, 0);
    tick();
    chk("s_mrst_busy", busy_s, 0);
    chk("s_mrst_de", de_s, 0);
    chk("s_mrst_rd", rd_en_s, 0);
    chk("s_mrst_addr", addr_s, 0);
    chk("s_mrst_sync", {hs_s, vs_s}, 2'b11);
    chk("s_mrst_fs", fs_s, 0);
    chk("s_mrst_pix", {r_s, g_s, b_s}, 0);

    rst_s = 1'b0;
    tick();
    rd_err_s = 0; de_err_s = 0; pix_err_s = 0; pidx_s = 0;
    for (int c = 1; c <= 131; c++) begin
      tick();
      exp_rd = s_active(c - 1) && ((c - 1) % 2 == 0);
      if (rd_en_s !== exp_rd || (exp_rd && addr_s !== 19'(s_addr(c - 1)))) rd_err_s++;
      exp_de = (c >= 3) && s_active(c - 3);
      if (de_s !== exp_de) de_err_s++;
      if (de_s) begin
        if ({r_s, b_s, g_s} !== exp_pix(pidx_s, 32)) pix_err_s++;
        pidx_s++;
      end
      if (c == 3) chk("s_clean_fs", fs_s, 1);
    end
    chk("s_clean_rd", rd_err_s, 0);
    chk("s_clean_de", de_err_s, 0);
    chk("s_clean_pix", pix_err_s, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_scanout.md
Name: frame_scanout

Overview:
- Downstream neighbour of the frame-buffer test-pattern writer.
- Reads the frame buffer over a fixed-latency read port, one 48-bit word holding two packed pixels.
- Generates VGA/HDMI raster timing (hsync, vsync, de) at the pixel clock.
- Unpacks each word into one 24-bit pixel per clock, aligned with de, for the HDMI transmitter/encoder.

Parameters:
- H_ACTIVE, 640, active pixels per line (must be even).
- H_FP, 16, horizontal front porch, pixels.
- H_SYNC, 96, hsync width, pixels.
- H_BP, 48, horizontal back porch, pixels.
- V_ACTIVE, 480, active lines.
- V_FP, 10, vertical front porch, lines.
- V_SYNC, 2, vsync width, lines.
- V_BP, 33, vertical back porch, lines.
- HS_POL, 0, hsync active level (0 = active-low).
- VS_POL, 0, vsync active level.
- RD_LAT, 2, memory read latency, cycles from rd_en to rd_data valid (1..4).
- ADDR_W, 19, frame-buffer word address width.

Ports:
- clk24, in, 1, pixel clock.
- rst, in, 1, synchronous active-high reset.
- en, in, 1, scan enable; sampled at frame boundaries.
- rd_addr, out, ADDR_W, frame-buffer word address.
- rd_en, out, 1, read strobe.
- rd_data, in, 48, word returned RD_LAT cycles after rd_en.
  - [23:0] = pixel 2k; [47:24] = pixel 2k+1.
  - Within a pixel: [23:16] = R, [15:8] = B, [7:0] = G.
- hsync, out, 1, horizontal sync.
- vsync, out, 1, vertical sync.
- de, out, 1, data enable.
- pix_r, out, 8, red.
- pix_g, out, 8, green.
- pix_b, out, 8, blue.
- frame_start, out, 1, one-cycle pulse coincident with the first active pixel of each frame.
- busy, out, 1, high while in RUN.

Behaviour:
- Interface: one clock, clk24; reset rst is synchronous and active-high.
- Reset values:
  - hsync = ~HS_POL, vsync = ~VS_POL.
  - de = 0, pix_r/g/b = 0, rd_en = 0, rd_addr = 0, frame_start = 0, busy = 0.
  - State = IDLE; h = 0, v = 0; word address = 0; pipeline cleared to inactive values.
- Raster counters:
  - H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - h counts 0..H_TOT-1.
  - v increments when h wraps; v wraps to 0 after V_TOT-1.
- Timing decode at raster position (h, v):
  - Active when h < H_ACTIVE and v < V_ACTIVE.
  - hsync active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync active for whole lines with V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
- Reads:
  - rd_en = 1 in the cycle after an active position with h even; rd_addr = v*(H_ACTIVE/2) + h/2 in that cycle.
  - Implement rd_addr with an incrementing word counter, not a multiplier.
  - The word counter resets to 0 at frame start and does not advance on blanking lines.
- Pipeline:
  - Total output latency L = RD_LAT+1 cycles from raster position to output.
  - hsync, vsync, de, the h[0] select bit and the frame_start tag are delayed L cycles to align with returned data.
  - The returned word is held in a register so the odd pixel, one cycle later, uses the same word.
  - Pixel select: h[0] = 0 gives pixel [23:0]; h[0] = 1 gives pixel [47:24].
  - Outputs are registered. When de = 0, pix_r/g/b = 0.
- State machine:
  - IDLE: counters held at (0,0); no reads. en = 1 → RUN on the next cycle, starting at (0,0).
  - RUN: busy = 1; rasters continuously.
  - At (H_TOT-1, V_TOT-1): en = 0 → IDLE; otherwise wrap to (0,0).
  - en deasserted mid-frame has no effect until the frame completes; full frames only.
- IDLE → RUN → IDLE transitions: the pipeline drains naturally. Outputs return to inactive levels L cycles after leaving RUN.
- frame_start: tagged at (0,0) in RUN, emitted L cycles later, so it coincides with the first de = 1.
- rst during RUN: the next cycle is in the reset state. No partial line is completed, and no rd_en is issued in or after the reset cycle.
- rd_data is ignored whenever the aligned de is 0.

Test Plan:
- Reset: assert rst for 3 cycles with en = 1 → all outputs at reset values; hsync = 1 and vsync = 1 (active-low); no rd_en.
- First line: en = 1 with defaults and a model memory with RD_LAT = 2 → rd_addr runs 0..319, one rd_en every 2 cycles; de high for exactly 640 cycles; first de 3 cycles after the raster reaches (0,0); frame_start pulses with the first de.
- Unpack: memory word k = {24'h00FF00+k, 24'hFF0000+k} → alternating pixels; even pixel R = FF, B = 00, G = k[7:0]; odd pixel B = FF; ordering exact per pixel.
- Sync timing: across one frame → hsync low for 96 cycles, starting 656 cycles after line start in output time; 800-cycle line period; vsync low for 2 lines, starting at line 490; 525 lines per frame; line 1 starts at rd_addr 320; last active word address 153599.
- en drop mid-frame: en = 0 at line 100 → frame completes through line 524, then busy = 0; no further rd_en; outputs inactive 3 cycles later. Re-assert en → new frame starting at rd_addr 0.
- Mid-frame reset, plus RD_LAT = 4 variant: reset at line 200 → immediate reset state, then a clean restart from (0,0) when en = 1. With RD_LAT = 4, latency is 5 and the data/de alignment check passes.
